// File: rtl/render_scheduler_if.sv
// render_scheduler_if: handshake bundle between the render scheduler and its
// clear engine, triangle memory, rasterizer and framebuffer swap logic.
interface render_scheduler_if #(
    parameter int TRI_ADDR_WIDTH = 8,
    parameter int TRI_DATA_WIDTH = 96
);
    logic                      frame_start_in;
    logic [TRI_ADDR_WIDTH:0]   tri_count_in;
    logic                      clear_start_out;
    logic                      clear_done_in;
    logic [TRI_ADDR_WIDTH-1:0] tri_addr_out;
    logic                      tri_rd_out;
    logic [TRI_DATA_WIDTH-1:0] tri_data_in;
    logic [TRI_DATA_WIDTH-1:0] rast_tri_out;
    logic                      rast_start_out;
    logic                      rast_busy_in;
    logic                      rast_done_in;
    logic                      swap_req_out;
    logic                      swap_ack_in;
    logic                      busy_out;
    logic                      frame_done_out;
    logic                      error_out;

    modport slave (
        input  frame_start_in, tri_count_in, clear_done_in, tri_data_in,
               rast_busy_in, rast_done_in, swap_ack_in,
        output clear_start_out, tri_addr_out, tri_rd_out, rast_tri_out,
               rast_start_out, swap_req_out, busy_out, frame_done_out, error_out
    );

    modport master (
        output frame_start_in, tri_count_in, clear_done_in, tri_data_in,
               rast_busy_in, rast_done_in, swap_ack_in,
        input  clear_start_out, tri_addr_out, tri_rd_out, rast_tri_out,
               rast_start_out, swap_req_out, busy_out, frame_done_out, error_out
    );
endinterface

// File: rtl/render_scheduler.sv
// render_scheduler: per-frame sequencer (clear -> fetch/raster each triangle -> swap).
// Define RENDER_TIMEOUT_EN to add the rasterizer watchdog and sticky error_out.
module render_scheduler #(
    parameter int TRI_ADDR_WIDTH = 8,
    parameter int TRI_DATA_WIDTH = 96,
    parameter int MEM_LATENCY    = 2,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic              clk_in,
    input  logic              rst_in,
    render_scheduler_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CLEAR, FETCH, WAIT_DATA, START, RASTER, SWAP} state_t;

    localparam int CW    = TRI_ADDR_WIDTH + 1;
    localparam int LAT_W = $clog2(MEM_LATENCY + 1);

    if (MEM_LATENCY < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("render_scheduler: MEM_LATENCY and TIMEOUT_CYCLES must be >= 1");
    end

    state_t                    state;
    logic [CW-1:0]             cnt, idx, idx_inc;
    logic [LAT_W-1:0]          lat_cnt;
    logic                      last_tri, timeout;
    logic                      clear_start_q, tri_rd_q, rast_start_q;
    logic                      swap_req_q, busy_q, frame_done_q;
    logic [TRI_ADDR_WIDTH-1:0] tri_addr_q;
    logic [TRI_DATA_WIDTH-1:0] rast_tri_q;

    // Index is one bit wider than the address so a full 2^N count terminates.
    assign idx_inc  = idx + 1'b1;
    assign last_tri = (idx_inc >= cnt);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state         <= IDLE;
            cnt           <= '0;
            idx           <= '0;
            lat_cnt       <= '0;
            clear_start_q <= 1'b0;
            tri_rd_q      <= 1'b0;
            rast_start_q  <= 1'b0;
            swap_req_q    <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            tri_addr_q    <= '0;
            rast_tri_q    <= '0;
        end else begin
            clear_start_q <= 1'b0;
            tri_rd_q      <= 1'b0;
            rast_start_q  <= 1'b0;
            frame_done_q  <= 1'b0;
            case (state)
                IDLE: if (bus.frame_start_in) begin
                    cnt           <= bus.tri_count_in;
                    idx           <= '0;
                    clear_start_q <= 1'b1;
                    busy_q        <= 1'b1;
                    state         <= CLEAR;
                end
                CLEAR: if (bus.clear_done_in) begin
                    if (cnt != '0) state <= FETCH;
                    else begin
                        swap_req_q <= 1'b1;
                        state      <= SWAP;
                    end
                end
                FETCH: begin
                    tri_addr_q <= idx[TRI_ADDR_WIDTH-1:0];
                    tri_rd_q   <= 1'b1;
                    lat_cnt    <= '0;
                    state      <= WAIT_DATA;
                end
                // lat_cnt is 0 in the strobe cycle, so data is taken MEM_LATENCY cycles later.
                WAIT_DATA: if (lat_cnt == LAT_W'(MEM_LATENCY)) begin
                    rast_tri_q <= bus.tri_data_in;
                    lat_cnt    <= '0;
                    state      <= START;
                end else begin
                    lat_cnt <= lat_cnt + 1'b1;
                end
                START: if (!bus.rast_busy_in) begin
                    rast_start_q <= 1'b1;
                    state        <= RASTER;
                end
                RASTER: if (bus.rast_done_in || timeout) begin
                    idx <= idx_inc;
                    if (last_tri) begin
                        swap_req_q <= 1'b1;
                        state      <= SWAP;
                    end else begin
                        state <= FETCH;
                    end
                end
                SWAP: if (bus.swap_ack_in) begin
                    swap_req_q   <= 1'b0;
                    frame_done_q <= 1'b1;
                    busy_q       <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RENDER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wdog;
    logic            error_q;

    assign timeout = (state == RASTER) && (wdog == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wdog    <= '0;
            error_q <= 1'b0;
        end else begin
            if (state == START && !bus.rast_busy_in) wdog <= '0;
            else if (state == RASTER)                wdog <= wdog + 1'b1;
            if (state == IDLE && bus.frame_start_in)  error_q <= 1'b0;
            else if (timeout && !bus.rast_done_in)    error_q <= 1'b1;
        end
    end
    assign bus.error_out = error_q;
`else
    assign timeout       = 1'b0;
    assign bus.error_out = 1'b0;
`endif

    assign bus.clear_start_out = clear_start_q;
    assign bus.tri_addr_out    = tri_addr_q;
    assign bus.tri_rd_out      = tri_rd_q;
    assign bus.rast_tri_out    = rast_tri_q;
    assign bus.rast_start_out  = rast_start_q;
    assign bus.swap_req_out    = swap_req_q;
    assign bus.busy_out        = busy_q;
    assign bus.frame_done_out  = frame_done_q;
endmodule

// File: tb/tb_render_scheduler.sv
// tb_render_scheduler: frame-level bench with memory, clear, rasterizer and swap
// responders; expectations come from per-frame rules (reads 0..N-1, N starts, one done).
module tb_render_scheduler;
    localparam int AW  = 4;
    localparam int CW  = AW + 1;
    localparam int DW  = 96;
    localparam int LAT = 2;
    localparam int TMO = 100;
    localparam int NT  = 1 << AW;

    typedef struct {
        int cnt; int clr; int dn; int ack; int busy;
        bit mid; bit stray; bit hang;
        int exp_starts; int exp_frames;
    } vec_t;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    always #5 clk_in = ~clk_in;

    render_scheduler_if #(.TRI_ADDR_WIDTH(AW), .TRI_DATA_WIDTH(DW)) bus ();

    render_scheduler #(
        .TRI_ADDR_WIDTH(AW), .TRI_DATA_WIDTH(DW),
        .MEM_LATENCY(LAT), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .bus   (bus.slave)
    );

    int n_tests = 0, n_fail = 0;
    int cyc = 0;
    int n_rd, n_start, n_frame, n_clear, n_swap;
    int e_addr, e_flight, e_busy, e_data, e_stable;
    int clr_pend = 0, done_pend = 0, busy_hold = 0, ack_pend = 0;
    int start_cyc, err_cyc;
    bit in_flight = 0, ack_armed = 0, err_seen = 0;
    int c_clr = 1, c_dn = 1, c_ack = 0, c_busy = 0;
    bit c_hang = 0, c_rbusy = 0, c_rstray = 0;
    logic [DW-1:0] mem [0:NT-1];
    logic [DW-1:0] held;
    bit            pv [1:LAT+1];
    logic [AW-1:0] pa [1:LAT+1];
    logic r_clear_done = 1'b0, stray_clear = 1'b0;

    assign bus.clear_done_in = r_clear_done | stray_clear;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_clear_start"}, bus.clear_start_out, 0);
        chk({tag, "_tri_addr"},    bus.tri_addr_out, 0);
        chk({tag, "_tri_rd"},      bus.tri_rd_out, 0);
        chk({tag, "_rast_tri"},    bus.rast_tri_out, 0);
        chk({tag, "_rast_start"},  bus.rast_start_out, 0);
        chk({tag, "_swap_req"},    bus.swap_req_out, 0);
        chk({tag, "_busy"},        bus.busy_out, 0);
        chk({tag, "_frame_done"},  bus.frame_done_out, 0);
        chk({tag, "_error"},       bus.error_out, 0);
    endtask

    // Environment: memory pipeline, clear engine, rasterizer, swap acker, event monitor.
    initial begin
        bus.rast_busy_in = 0; bus.rast_done_in = 0; bus.swap_ack_in = 0; bus.tri_data_in = '0;
        for (int k = 1; k <= LAT + 1; k++) begin pv[k] = 0; pa[k] = '0; end
        forever begin
            @(negedge clk_in);
            cyc++;
            if (rst_in) begin
                clr_pend = 0; done_pend = 0; busy_hold = 0; ack_pend = 0;
                in_flight = 0; ack_armed = 0;
                r_clear_done = 0; bus.rast_done_in = 0; bus.rast_busy_in = 0; bus.swap_ack_in = 0;
                for (int k = 1; k <= LAT + 1; k++) pv[k] = 0;
            end else begin
                if (bus.clear_start_out) begin n_clear++; clr_pend = c_clr; end
                if (bus.tri_rd_out) begin
                    if (in_flight) e_flight++;
                    if (bus.tri_addr_out !== AW'(n_rd)) e_addr++;
                    n_rd++;
                    if (c_busy > 0) busy_hold = c_busy;
                end
                if (bus.rast_start_out) begin
                    if (bus.rast_busy_in) e_busy++;
                    if (n_start >= NT || bus.rast_tri_out !== mem[n_start]) e_data++;
                    held = bus.rast_tri_out;
                    n_start++;
                    in_flight = 1;
                    if (c_hang && n_start == 1) begin start_cyc = cyc; done_pend = 0; end
                    else done_pend = c_dn;
                end else if (in_flight && bus.rast_tri_out !== held) e_stable++;
                if (bus.error_out && !err_seen) begin
                    err_seen = 1; err_cyc = cyc;
                    if (c_hang) in_flight = 0;
                end
                if (bus.frame_done_out) n_frame++;
                if (bus.swap_req_out) n_swap++;

                r_clear_done = 0;
                if (clr_pend > 0) begin clr_pend--; if (clr_pend == 0) r_clear_done = 1; end
                bus.rast_done_in = 0;
                if (done_pend > 0) begin
                    done_pend--;
                    if (done_pend == 0) begin bus.rast_done_in = 1; in_flight = 0; end
                end else if (!in_flight && c_rstray && $urandom_range(0, 7) == 0) begin
                    bus.rast_done_in = 1;
                end
                if (c_rbusy && busy_hold == 0 && $urandom_range(0, 15) == 0)
                    busy_hold = $urandom_range(1, 6);
                bus.rast_busy_in = 0;
                if (busy_hold > 0) begin bus.rast_busy_in = 1; busy_hold--; end
                bus.swap_ack_in = 0;
                if (!bus.swap_req_out) begin
                    ack_armed = 0; ack_pend = 0;
                end else if (!ack_armed) begin
                    ack_armed = 1;
                    if (c_ack == 0) bus.swap_ack_in = 1; else ack_pend = c_ack;
                end else if (ack_pend > 0) begin
                    ack_pend--;
                    if (ack_pend == 0) bus.swap_ack_in = 1;
                end
                for (int k = LAT + 1; k >= 2; k--) begin pv[k] = pv[k-1]; pa[k] = pa[k-1]; end
                pv[1] = bus.tri_rd_out; pa[1] = bus.tri_addr_out;
            end
            bus.tri_data_in = pv[LAT+1] ? mem[pa[LAT+1]] : {$urandom, $urandom, $urandom};
        end
    end

    task automatic run_frame(input vec_t v, input bit from_reset);
        c_clr = v.clr; c_dn = v.dn; c_ack = v.ack; c_busy = v.busy; c_hang = v.hang;
        n_rd = 0; n_start = 0; n_frame = 0; n_clear = 0; n_swap = 0;
        e_addr = 0; e_flight = 0; e_busy = 0; e_data = 0; e_stable = 0; err_seen = 0;
        for (int i = 0; i < NT; i++) mem[i] = {$urandom, $urandom, $urandom};
        if (from_reset) rst_in = 1'b0;
        else @(negedge clk_in);
        bus.tri_count_in = CW'(v.cnt); bus.frame_start_in = 1; stray_clear = v.stray;
        @(negedge clk_in);
        bus.frame_start_in = 0; stray_clear = 0;
        chk("accept_clear_start", bus.clear_start_out, 1);
        chk("accept_error_clear", bus.error_out, 0);
        for (int i = 0; i < 20000 && n_frame == 0; i++) begin
            @(negedge clk_in);
            bus.frame_start_in = v.mid && (i == 40);
        end
        bus.frame_start_in = 0;
        repeat (30) @(negedge clk_in);
        chk("frame_done_count", n_frame, v.exp_frames);
        chk("rast_start_count", n_start, v.exp_starts);
        chk("tri_rd_count",     n_rd, v.exp_starts);
        chk("clear_start_count", n_clear, 1);
        chk("read_addr_order",  e_addr, 0);
        chk("one_in_flight",    e_flight, 0);
        chk("start_while_busy", e_busy, 0);
        chk("rast_tri_data",    e_data, 0);
        chk("rast_tri_stable",  e_stable, 0);
        chk("idle_busy",        bus.busy_out, 0);
        chk("idle_swap_req",    bus.swap_req_out, 0);
        chk("error_at_end",     bus.error_out, v.hang);
        if (v.hang) chk("watchdog_delay", err_cyc - start_cyc, TMO);
    endtask

    initial begin
        vec_t tbl [6];
        vec_t v;
        bus.frame_start_in = 0; bus.tri_count_in = '0;
        //          cnt clr dn ack busy mid stray hang  starts frames
        tbl[0] = '{3,  10, 50, 0,  0,  0,  0,    0,    3,     1};
        tbl[1] = '{0,  4,  5,  0,  0,  0,  0,    0,    0,     1};
        tbl[2] = '{2,  3,  6,  1,  20, 1,  0,    0,    2,     1};
        tbl[3] = '{16, 2,  3,  2,  0,  0,  0,    0,    16,    1};
        tbl[4] = '{1,  1,  1,  0,  0,  0,  1,    0,    1,     1};
        tbl[5] = '{5,  2,  1,  3,  0,  0,  0,    0,    5,     1};

        repeat (3) @(negedge clk_in);
        chk_outputs_zero("reset");
        run_frame(tbl[0], 1'b1);
        for (int i = 1; i < 6; i++) run_frame(tbl[i], 1'b0);

`ifdef RENDER_TIMEOUT_EN
        v = '{2, 2, 4, 0, 0, 0, 0, 1, 2, 1};
        run_frame(v, 1'b0);
        run_frame(tbl[4], 1'b0);
`endif

        c_rbusy = 1; c_rstray = 1;
        for (int i = 0; i < 20; i++) begin
            v.cnt = $urandom_range(0, NT); v.clr = $urandom_range(1, 5);
            v.dn = $urandom_range(1, 8); v.ack = $urandom_range(0, 3);
            v.busy = 0; v.mid = 0; v.stray = $urandom_range(0, 1); v.hang = 0;
            v.exp_starts = v.cnt; v.exp_frames = 1;
            run_frame(v, 1'b0);
        end
        c_rbusy = 0; c_rstray = 0;

        // Reset while triangle 1 of 4 is in the rasterizer.
        c_clr = 2; c_dn = 30; c_ack = 0; c_busy = 0; c_hang = 0;
        n_start = 0; n_frame = 0; n_rd = 0;
        @(negedge clk_in);
        bus.tri_count_in = CW'(4); bus.frame_start_in = 1;
        @(negedge clk_in);
        bus.frame_start_in = 0;
        for (int i = 0; i < 2000 && n_start < 2; i++) @(negedge clk_in);
        chk("midreset_reached_tri1", n_start, 2);
        #2 rst_in = 1'b1;
        n_frame = 0; n_swap = 0;
        #1 chk_outputs_zero("midreset");
        repeat (5) @(negedge clk_in);
        chk("midreset_no_frame_done", n_frame, 0);
        chk("midreset_no_swap_req", n_swap, 0);
        v = '{4, 2, 3, 0, 0, 0, 0, 0, 4, 1};
        run_frame(v, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
